// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, controller state type and an op classification helper.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // True for the four operations that run through the iterative datapath.
  function automatic logic is_iterative(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add when
// mode is 0, restoring shift-subtract when mode is 1.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    ge      = 1'b0;
    acc_o   = acc_i;
    if (!mode) begin
      // Low half holds the remaining multiplier bits; the add carry is kept
      // and shifted into the product so no bit is lost.
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      // The shifted partial remainder needs one extra bit before comparing.
      shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      ge      = (shifted >= {1'b0, opnd});
      acc_o   = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                 acc_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers. MULT/DIV take
// WIDTH+1 cycles (WIDTH iterations plus a sign/special-case fix cycle).
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               mode_q, mode_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               divz_q, divz_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept;

  assign sgn    = is_signed_op(op);
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;
  assign accept = start && !flush && (state_q == ST_IDLE);

  assign mul_res = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_q[2*WIDTH-1:WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode  (mode_q),
    .acc_i (acc_q),
    .opnd  (opnd_q),
    .acc_o (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iterative(op)) begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(WIDTH - 1);
            araw_d  = a;
            neg_d   = a_neg ^ b_neg;
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
              // Dividend magnitude in the low half becomes the quotient.
              mode_d = 1'b1;
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
              rneg_d = a_neg;
              divz_d = (b == '0);
              ovf_d  = sgn && (a == MIN_NEG) && (b == {WIDTH{1'b1}});
            end else begin
              mode_d = 1'b0;
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
              rneg_d = 1'b0;
              divz_d = 1'b0;
              ovf_d  = 1'b0;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!mode_q) begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end else if (divz_q) begin
          hi_d = araw_q;
          lo_d = {WIDTH{1'b1}};
        end else if (ovf_q) begin
          hi_d = '0;
          lo_d = araw_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush cancels whatever the active state would have committed.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the architectural definitions.
  task automatic ref_calc(input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          output logic [W-1:0] eh, output logic [W-1:0] el);
    int          ia, ib;
    longint      ps;
    logic [63:0] pu;
    ia = signed'(av);
    ib = signed'(bv);
    eh = m_hi;
    el = m_lo;
    case (o)
      3'd0: begin
        ps = longint'(ia) * longint'(ib);
        {eh, el} = ps;
      end
      3'd1: begin
        pu = {32'd0, av} * {32'd0, bv};
        {eh, el} = pu;
      end
      3'd2: begin
        if (bv == 0) begin
          el = '1; eh = av;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          el = av; eh = '0;
        end else begin
          el = ia / ib; eh = ia % ib;
        end
      end
      3'd3: begin
        if (bv == 0) begin
          el = '1; eh = av;
        end else begin
          el = av / bv; eh = av % bv;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit b2b,
                        input string name);
    logic [W-1:0] eh, el;
    int n;
    bit got, drop;
    ref_calc(o, av, bv, eh, el);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept got %b want 1", name, busy);
    end
    n = 0; got = 0; drop = 0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1;
      else if (busy !== 1'b1) drop = 1;
    end
    checks++;
    if (!got || drop || n != LAT) begin
      errors++;
      $display("FAIL %s latency got %0d (done=%b early_drop=%b) want %0d", name, n, got, drop, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_in_done_cycle got %b want 0", name, busy);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, eh, el);
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", o, av, bv, hi, lo, n);
    m_hi = eh; m_lo = el;
    if (!b2b) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL %s done_one_cycle got %b want 0", name, done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg3x7");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max_b2b");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
    run_op(3'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(3'd3, 32'd7, 32'd0, 1'b0, "divu_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, "div_by_zero_signed");
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      o  = 3'($urandom_range(0, 3));
      av = $urandom();
      bv = $urandom();
      case ($urandom_range(0, 7))
        0: bv = '0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: bv = 32'($urandom_range(1, 15));
        3: av = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(o, av, bv, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_mt();
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    m_hi = 32'h1234_5678;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h busy=0 done=0", hi, lo, busy, done, m_hi, m_lo);
    end
    $display("mthi a=%h -> hi=%h lo=%h", a, hi, lo);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_0001;
    @(posedge clk); #1;
    start = 1'b0;
    m_lo = 32'hCAFE_0001;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h busy=0 done=0", hi, lo, busy, done, m_hi, m_lo);
    end
    $display("mtlo a=%h -> hi=%h lo=%h", a, hi, lo);
  endtask

  task automatic test_flush();
    bit saw_done;
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || lo !== m_lo) begin
      errors++;
      $display("FAIL start_while_busy got busy=%b lo=%h want busy=1 lo=%h", busy, lo, m_lo);
    end
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_busy got busy=%b done=%b want 0 0", busy, done);
    end
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_no_write got activity=%b hi=%h lo=%h want 0 hi=%h lo=%h", saw_done, hi, lo, m_hi, m_lo);
    end
    $display("flush: busy=%b hi=%h lo=%h", busy, hi, lo);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL flush_idle got busy=%b hi=%h lo=%h", busy, hi, lo);
    end
  endtask

  task automatic test_start_flush();
    bit act;
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_flush_mult got busy=%b want 0", busy);
    end
    op = 3'd4; a = 32'h0BAD_F00D;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (hi !== m_hi || busy !== 1'b0) begin
      errors++; $display("FAIL start_flush_mthi got hi=%h busy=%b want hi=%h busy=0", hi, busy, m_hi);
    end
    act = 0;
    repeat (36) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) act = 1;
    end
    checks++;
    if (act) begin
      errors++; $display("FAIL start_flush_activity got 1 want 0");
    end
    $display("start+flush: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_undef();
    bit act;
    for (int k = 6; k <= 7; k++) begin
      start = 1'b1; op = 3'(k); a = 32'h5555_AAAA; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL undef_op%0d got busy=%b hi=%h lo=%h want 0 %h %h", k, busy, hi, lo, m_hi, m_lo);
      end
      act = 0;
      repeat (36) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) act = 1;
      end
      checks++;
      if (act) begin
        errors++; $display("FAIL undef_op%0d_activity got 1 want 0", k);
      end
      $display("undef op=%0d: busy=%b hi=%h lo=%h", k, busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0000_0777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    $display("reset mid-op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    repeat (36) begin @(posedge clk); #1; end
    checks++;
    if (done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL reset_mid_late got done=%b hi=%h lo=%h want 0", done, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_mt();
    test_flush();
    test_start_flush();
    test_undef();
    test_random();
    test_mt();
    test_reset_mid();
    run_op(3'd1, 32'd6, 32'd7, 1'b0, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the 5-cycle MIPS core. It sits beside the combinational EX-stage ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU with a fixed WIDTH+1 cycle latency, plus single-cycle MTHI/MTLO writes.
- Decode stalls the pipeline on `busy`. The exception logic cancels in-flight work through `flush`.

Parameters:
- WIDTH, 32: operand/HI/LO width. Legal values are even and >= 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk    in   1      rising-edge clock
- rst_n  in   1      synchronous reset, active-low. Sampled on the rising edge of clk.
- start  in   1      request. `op`, `a`, `b` are valid when high.
- op     in   3      operation code (package encoding)
- a      in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b      in   WIDTH  rt operand (multiplier / divisor)
- flush  in   1      cancel any in-flight operation
- busy   out  1      operation in progress. `start` is ignored while high.
- done   out  1      one-cycle pulse: HI/LO were just updated by MULT/DIV
- hi     out  WIDTH  HI register
- lo     out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and datapath registers cleared. Reset mid-operation aborts with no HI/LO write.
- All outputs are registered. No combinational path from inputs to outputs.
- Acceptance: start=1 && busy=0 && flush=0 at edge E0. If flush=1 in the same cycle, flush wins and nothing is accepted.
- MTHI/MTLO: when accepted, hi (resp. lo) <= a at E0. Single cycle: busy stays 0 and done stays 0.
- MULT/MULTU/DIV/DIVU: operands are latched at E0. For signed ops, the magnitudes and the result-sign flags are latched. busy=1 after E0.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
  - CALC: WIDTH iterations, one per cycle. Counter counts WIDTH-1 down to 0.
  - Multiply: radix-2 shift-add on a 2*WIDTH product register.
  - Divide: restoring shift-subtract. Quotient is built in the low half, partial remainder in the high half.
  - FIX: one cycle. Applies sign correction and special cases, then writes HI/LO.
- Exact latency:
  - hi/lo written at edge E0+WIDTH+1.
  - done=1 for exactly the one cycle following that edge.
  - busy falls at that same edge, so busy is high for exactly WIDTH+1 cycles.
  - A new start may be accepted in the done cycle.
- Multiply results: {hi,lo} = full 2*WIDTH product. Signed uses two's-complement operands; unsigned uses the raw operands.
- Divide results:
  - lo = quotient, truncated toward zero; hi = remainder, sign follows the dividend.
  - Divide by zero (signed or unsigned): lo = all ones, hi = a.
  - Signed overflow (a = most negative, b = -1): lo = a, hi = 0.
  - Special cases take the same WIDTH+1 latency. They are detected at E0 and applied in FIX.
- flush while busy: return to IDLE at the next edge. No HI/LO write, no done pulse, busy=0 after that edge.
- flush while IDLE: no effect.
- start while busy: ignored, with no queuing. Decode must hold the instruction until busy=0.
- Undefined op codes: accepted as a no-op. No busy, no write.

Decomposition:
- Package `mdu_pkg`:
  - op encoding: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5; 6-7 reserved.
  - FSM state typedef (IDLE, CALC, FIX).
- Sub-module `mdu_step`: combinational single-iteration datapath. Shift-add or shift-subtract, selected by a mode bit. Instantiated once; the FSM and registers stay in muldiv_unit.

Test Plan:
- Reset: all outputs 0. MULT a=0xFFFFFFFD (-3), b=7 -> after exactly 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high for one cycle; busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start in the done cycle is accepted.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Special cases:
  - DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Both in 33 cycles.
- MTHI a=0x12345678 -> hi=0x12345678 next edge, busy=0, done=0.
  - Then start DIV; assert a second start at cycle 5 (ignored).
  - Assert flush at cycle 10 -> busy=0 next edge, no done, hi still 0x12345678.
- rst_n=0 at cycle 20 of a MULT -> all outputs 0 next edge. start+flush in the same cycle -> not accepted.
